// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state type, default sizes and lane extraction helper
package systolic_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FEED, ST_DRAIN} sched_state_t;

  localparam int DEF_N       = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int LANE_VEC_W  = 4096;
  localparam int LANE_ELEM_W = 64;

  // Vectors are zero-extended into the fixed helper width; callers cast the element back down.
  function automatic logic [LANE_ELEM_W-1:0] lane_sel(input logic [LANE_VEC_W-1:0] vec,
                                                      input int unsigned lane,
                                                      input int unsigned elem_w);
    return LANE_ELEM_W'(vec >> (lane * elem_w));
  endfunction

endpackage

// File: rtl/skew_column_select.sv
// rtl/skew_column_select.sv - combinational column picker from the tile buffer, skewed or straight
module skew_column_select
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FCW    = $clog2(2*N)
) (
  input  logic [N*N*DATA_W-1:0] tile_i,
  input  logic [FCW-1:0]        feed_cnt_i,
  input  logic                  skew_en_i,
  output logic [N*DATA_W-1:0]   col_data_o,
  output logic [N-1:0]          col_valid_o
);

  int row;

  always_comb begin
    col_data_o  = '0;
    col_valid_o = '0;
    row         = 0;
    for (int i = 0; i < N; i++) begin
      // Lane i lags lane 0 by i columns when skewing, so it reads row t-i.
      row = skew_en_i ? int'(feed_cnt_i) - i : int'(feed_cnt_i);
      if (row >= 0 && row < N) begin
        col_valid_o[i] = 1'b1;
        col_data_o[i*DATA_W +: DATA_W] =
          DATA_W'(lane_sel(LANE_VEC_W'(tile_i), unsigned'(row*N + i), unsigned'(DATA_W)));
      end
    end
  end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// rtl/systolic_feed_scheduler.sv - loads an NxN tile, streams it into the array, drains, pulses done
// Define SYSTOLIC_SKEW_EN for internal diagonal skew (2N-1 columns); otherwise N straight rows.
module systolic_feed_scheduler
  import systolic_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DRAIN_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                hold_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N*DATA_W-1:0] in_data_i,
  output logic [N*DATA_W-1:0] out_data_o,
  output logic [N-1:0]        out_lane_valid_o,
  output logic                busy_o,
  output logic                done_o
);

`ifdef SYSTOLIC_SKEW_EN
  localparam logic SKEW_EN = 1'b1;
  localparam int   F       = 2*N - 1;
`else
  localparam logic SKEW_EN = 1'b0;
  localparam int   F       = N;
`endif
  localparam int ROW_W = N*DATA_W;
  localparam int LCW   = $clog2(N);
  localparam int FCW   = $clog2(2*N);
  localparam int DCW   = $clog2(DRAIN_CYC+1);

  sched_state_t          state_q, state_d;
  logic [LCW-1:0]        load_cnt_q, load_cnt_d;
  logic [FCW-1:0]        feed_cnt_q, feed_cnt_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [N*ROW_W-1:0]    tile_q, tile_d;
  logic                  done_q, done_d;
  logic [ROW_W-1:0]      col_data;
  logic [N-1:0]          col_valid;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tile_d      = tile_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_cnt_d = '0;
        if (start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid_i) begin
          for (int r = 0; r < N; r++) begin
            if (load_cnt_q == LCW'(r)) tile_d[r*ROW_W +: ROW_W] = in_data_i;
          end
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LCW'(N-1)) begin
            state_d    = ST_FEED;
            feed_cnt_d = '0;
          end
        end
      end
      ST_FEED: begin
        if (!hold_i) begin
          if (feed_cnt_q == FCW'(F-1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end else begin
            feed_cnt_d = feed_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!hold_i) begin
          if (drain_cnt_q == DCW'(DRAIN_CYC-1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      tile_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tile_q      <= tile_d;
      done_q      <= done_d;
    end
  end

  skew_column_select #(.N(N), .DATA_W(DATA_W), .FCW(FCW)) u_col_sel (
    .tile_i      (tile_q),
    .feed_cnt_i  (feed_cnt_q),
    .skew_en_i   (SKEW_EN),
    .col_data_o  (col_data),
    .col_valid_o (col_valid)
  );

  // done is registered so it appears in the first IDLE cycle, free of any path from hold_i.
  assign in_ready_o       = (state_q == ST_LOAD);
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = done_q;
  assign out_data_o       = (state_q == ST_FEED) ? col_data : '0;
  assign out_lane_valid_o = (state_q == ST_FEED) ? col_valid : '0;

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// tb/tb_systolic_feed_scheduler.sv - self-checking bench for systolic_feed_scheduler (N=4, DATA_W=8, DRAIN_CYC=3)
module tb_systolic_feed_scheduler;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int D = 3;
`ifdef SYSTOLIC_SKEW_EN
  localparam bit SKEW = 1'b1;
  localparam int F = 2*N - 1;
`else
  localparam bit SKEW = 1'b0;
  localparam int F = N;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N*DW-1:0] out_data;
  logic [N-1:0] out_lane_valid;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] tile_rows [N];
  logic [31:0] cap_data [64];
  logic [3:0] cap_valid [64];

  systolic_feed_scheduler #(.N(N), .DATA_W(DW), .DRAIN_CYC(D)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_data_o(out_data), .out_lane_valid_o(out_lane_valid),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Column t of the tile as the array should see it, straight from the feeding rule.
  function automatic void model_col(input int t, output logic [31:0] d, output logic [3:0] v);
    int r;
    d = '0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      r = SKEW ? t - i : t;
      if (r >= 0 && r < N) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = tile_rows[r][i*DW +: DW];
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h required=0", out_data); end
    checks++; if (out_lane_valid !== '0) begin errors++; $display("FAIL reset_lane_valid got=%b required=0", out_lane_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", done); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b in_ready=%b required 0 0", busy, in_ready); end
  endtask

  task automatic test_tile(input string name, input bit bubbles, input int hold_at, input int hold_len, input int start_at);
    int r, accepts, drops, guard, s, done_seen, done_cnt, exp_t;
    logic [31:0] ed;
    logic [3:0] ev;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s_load_entry in_ready=%b busy=%b required 1 1", name, in_ready, busy); end
    r = 0; accepts = 0; drops = 0; guard = 0;
    while (r < N && guard < 40) begin
      in_valid = bubbles ? ((guard % 2) == 0) : 1'b1;
      in_data = in_valid ? tile_rows[r] : 32'($urandom);
      if (!in_ready) drops++;
      else if (in_valid) begin r++; accepts++; end
      @(posedge clk); @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    in_data = '0;
    checks++; if (accepts != N) begin errors++; $display("FAIL %s_accepts got=%0d required=%0d", name, accepts, N); end
    checks++; if (drops != 0) begin errors++; $display("FAIL %s_ready_drops got=%0d required=0", name, drops); end
    s = 0; done_seen = -1; done_cnt = 0;
    while (s < 60) begin
      cap_data[s] = out_data;
      cap_valid[s] = out_lane_valid;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_seen < 0) done_seen = s;
      end
      if (done_seen >= 0 && s >= done_seen + 4) break;
      hold = (s >= hold_at && s < hold_at + hold_len);
      start = (s == start_at);
      @(posedge clk); @(negedge clk);
      s++;
    end
    hold = 1'b0;
    start = 1'b0;
    for (int k = 0; k < F + hold_len + D; k++) begin
      if (hold_len > 0 && k > hold_at) exp_t = (k <= hold_at + hold_len) ? hold_at : k - hold_len;
      else exp_t = k;
      if (exp_t < F) model_col(exp_t, ed, ev);
      else begin ed = '0; ev = '0; end
      checks++;
      if (cap_data[k] !== ed || cap_valid[k] !== ev) begin
        errors++;
        $display("FAIL %s_col%0d data=%h valid=%b required data=%h valid=%b", name, k, cap_data[k], cap_valid[k], ed, ev);
      end
    end
    checks++; if (done_seen != F + D + hold_len) begin errors++; $display("FAIL %s_done_latency got=%0d required=%0d", name, done_seen, F + D + hold_len); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count got=%0d required=1", name, done_cnt); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL %s_idle_after_done busy=%b in_ready=%b required 0 0", name, busy, in_ready); end
  endtask

  task automatic test_nominal();
    logic [31:0] c3;
    tile_rows[0] = 32'h04030201;
    tile_rows[1] = 32'h14131211;
    tile_rows[2] = 32'h24232221;
    tile_rows[3] = 32'h34333231;
    c3 = SKEW ? 32'h04132231 : 32'h34333231;
    test_tile("nominal", 1'b0, -1, 0, -1);
    checks++; if (cap_data[3] !== c3 || cap_valid[3] !== 4'hf) begin errors++; $display("FAIL nominal_col3_const data=%h valid=%b required data=%h valid=1111", cap_data[3], cap_valid[3], c3); end
    checks++; if (cap_valid[0] !== (SKEW ? 4'b0001 : 4'b1111)) begin errors++; $display("FAIL nominal_col0_valid got=%b", cap_valid[0]); end
  endtask

  task automatic randomize_rows();
    for (int r = 0; r < N; r++) tile_rows[r] = $urandom;
  endtask

  task automatic test_backpressure();
    randomize_rows();
    test_tile("backpressure", 1'b1, -1, 0, -1);
  endtask

  task automatic test_hold();
    randomize_rows();
    test_tile("hold", 1'b0, 2, 2, -1);
  endtask

  task automatic test_start_in_feed();
    randomize_rows();
    test_tile("start_in_feed", 1'b0, -1, 0, 2);
  endtask

  task automatic test_reset_midload();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = $urandom;
    @(posedge clk); @(negedge clk);
    in_data = $urandom;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midload_rst_in_ready got=%b required=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midload_rst_busy got=%b required=0", busy); end
    checks++; if (out_data !== '0 || out_lane_valid !== '0) begin errors++; $display("FAIL midload_rst_outputs data=%h valid=%b required 0 0", out_data, out_lane_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    randomize_rows();
    test_tile("reload_after_reset", 1'b0, -1, 0, -1);
  endtask

  task automatic test_random_tiles();
    for (int n = 0; n < 4; n++) begin
      randomize_rows();
      test_tile("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, F-1)), int'($urandom_range(0, 3)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_hold();
    test_start_in_feed();
    test_reset_midload();
    test_random_tiles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feed_scheduler.md
# systolic_feed_scheduler

Sequencing controller for the systolic array's input side. It accepts N input vectors of N lanes over a valid/ready handshake and holds them in an internal row buffer. It then streams them into the array as diagonally skewed columns, waits a programmable drain interval for the array to flush, and signals completion. It sits between the vector source (upstream of the lane-to-matrix conversion stage) and the array's west-edge inputs.

## Interface
- `N`, 16, lanes per vector and number of vectors per tile (power of two, ≥2)
- `DATA_W`, 8, element width in bits
- `DRAIN_CYC`, 16, cycles spent in DRAIN after the last column
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: one-cycle request to begin a tile; honoured only in IDLE
- `hold` input 1: freezes FEED/DRAIN progress while high
- `in_valid` input 1: upstream vector valid
- `in_ready` output 1: scheduler accepts a vector (high only in LOAD)
- `in_data` input N*DATA_W: vector, lane i at bits [i*DATA_W +: DATA_W]
- `out_data` output N*DATA_W: column presented to the array, lane i = array row i
- `out_lane_valid` output N: per-lane element valid
- `busy` output 1: state ≠ IDLE
- `done` output 1: one-cycle pulse at DRAIN→IDLE

## Operation
- States: IDLE, LOAD, FEED, DRAIN.
- IDLE:
  - `start`=1 → LOAD.
  - Load counter cleared.
- LOAD:
  - `in_ready`=1.
  - Each edge with `in_valid&&in_ready` writes `in_data` into buffer row r=load_cnt, then increments load_cnt.
  - The edge accepting row N-1 → FEED, with feed_cnt=0.
- FEED:
  - Lasts F = 2N-1 column cycles.
  - At column t, lane i shows buffer[t-i][i] when 0 ≤ t-i ≤ N-1; otherwise 0 with `out_lane_valid[i]`=0.
  - feed_cnt increments each cycle with `hold`=0.
  - The edge with feed_cnt=F-1 and `hold`=0 → DRAIN, with drain_cnt=0.
- DRAIN:
  - `out_data`=0, `out_lane_valid`=0.
  - drain_cnt increments when `hold`=0.
  - At drain_cnt=DRAIN_CYC-1 with `hold`=0 → IDLE, and `done` pulses on that cycle.
- `hold` in IDLE or LOAD has no effect. In FEED, `hold` freezes feed_cnt and the outputs repeat the same column.
- `start` outside IDLE is ignored. No queued start.
- Arithmetic:
  - load_cnt is clog2(N) bits.
  - feed_cnt is clog2(2N) bits.
  - drain_cnt is clog2(DRAIN_CYC+1) bits.
  - Counters never wrap inside a tile; they are reset on state entry.
- Reset, asynchronous, any state:
  - state=IDLE, all counters=0, buffer=0.
  - `in_ready`=0, `out_data`=0, `out_lane_valid`=0, `busy`=0, `done`=0.
  - A partially loaded tile is discarded.

## Timing
- All outputs decode from registered state, counters and buffer. There is no combinational path from inputs to outputs.
- `start` at edge k puts the block in LOAD from cycle k+1, where `in_ready`=1.
- With `in_valid` held high, the last accept is at edge k+N, and column 0 is visible in cycle k+N+1.
- Latency from last accept to `done`: F + DRAIN_CYC cycles, plus any `hold` cycles.
- Upstream may drop `in_valid` at any time. Bubbles extend LOAD only.

## Configuration
- `SYSTOLIC_SKEW_EN` defined:
  - Diagonal skew as above, F=2N-1.
- `SYSTOLIC_SKEW_EN` undefined:
  - Skew is done by external delay lines, so the block outputs unskewed rows.
  - F=N. Column t = buffer row t, and all lanes are valid.
  - Everything else is unchanged.

## Structure
- Shared package `systolic_pkg`:
  - State enum `sched_state_t`.
  - Default `DATA_W` and `N` localparams.
  - The `lane_sel` helper for extracting lane i from a packed vector.
- One sub-module, `skew_column_select`: purely combinational. It takes the buffer, feed_cnt and the skew mode, and returns `out_data` and `out_lane_valid`.
- Counters and the FSM stay in the top.

## Test plan
Bench uses N=4, DATA_W=8, DRAIN_CYC=3.

- Nominal, skew on:
  - Stimulus: load rows 0x04030201, 0x14131211, 0x24232221, 0x34333231.
  - Columns t=0..6:
    - `out_lane_valid` = 0001, 0011, 0111, 1111, 1110, 1100, 1000.
    - Column 3 `out_data` = 0x04132231.
  - `done` pulses 7+3 cycles after the last accept.
- Backpressure on input: toggle `in_valid` every other cycle → `in_ready` stays 1, exactly 4 accepts, FEED entered after the 4th.
- `hold` high for 2 cycles at t=2 → column 2 is held for 3 cycles and `done` is delayed by 2.
- `start` pulsed during FEED → ignored; exactly one `done`, then IDLE with `busy`=0.
- Reset asserted after 2 rows loaded → outputs 0 immediately, `busy`=0. A new `start` needs a full 4-row load.
- `SYSTOLIC_SKEW_EN` undefined with the same data:
  - 4 columns equal to rows 0..3, `out_lane_valid`=1111.
  - `done` 4+3 cycles after the last accept.
